// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Optional feature macro used by the fetch logic: IF_HALT_ON_NULL_EN.
package if_fetch_ctrl_pkg;

  localparam int WORD_WIDTH = 32;

  localparam logic [WORD_WIDTH-1:0] IF_PC_STEP    = WORD_WIDTH'(4);
  localparam logic [WORD_WIDTH-1:0] IF_NULL_INSTR = '0;

  typedef enum logic {
    IF_ST_RUN  = 1'b0,
    IF_ST_HALT = 1'b1
  } if_state_e;

  // One prefetch slot: the fetch address travels with its instruction word.
  typedef struct packed {
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Redirect targets are always word aligned; the low two bits are dropped.
  function automatic logic [WORD_WIDTH-1:0] align_word(input logic [WORD_WIDTH-1:0] addr);
    return addr & ~WORD_WIDTH'(3);
  endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch queue: circular buffer of fetch entries with wrap-bit pointers,
// a synchronous clear that wins over push/pop, and full/empty flags.
module if_prefetch_fifo
  import if_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         push_i,
  input  fetch_entry_t data_i,
  input  logic         pop_i,
  output fetch_entry_t data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;

  // Equal indices: same wrap bit means empty, opposite wrap bit means full.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state: clear resets both, otherwise advance on push/pop.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage write port.
  // NOTE: storage is deliberately not reset; the empty flag gates every read of stale data.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational
// instruction memory into a prefetch queue and presents the head to decode.
// A taken branch flushes the queue and redirects the PC (one-bubble penalty).
// Optional macro IF_HALT_ON_NULL_EN: a fetched null word stops fetching
// (HALT) until the next taken branch; queued words still drain.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int                    FIFO_DEPTH = 2,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic [WORD_WIDTH-1:0] imem_instr,
  input  logic                  br_taken,
  input  logic [WORD_WIDTH-1:0] br_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_instr,
  output logic [WORD_WIDTH-1:0] out_pc,
  output logic                  halted
);

  if_state_e             state_q, state_d;
  logic [WORD_WIDTH-1:0] pc_q, pc_d;
  logic                  push, pop, clr;
  logic                  fifo_full, fifo_empty;
  logic                  null_hit;
  fetch_entry_t          head;
  fetch_entry_t          fetched;

  assign imem_addr      = pc_q;
  assign fetched.pc     = pc_q;
  assign fetched.instr  = imem_instr;
  assign pop            = out_valid && out_ready;

  // Head is forced to zero while empty so the interface never shows stale storage.
  assign out_valid = !fifo_empty;
  assign out_instr = fifo_empty ? '0 : head.instr;
  assign out_pc    = fifo_empty ? '0 : head.pc;

`ifdef IF_HALT_ON_NULL_EN
  assign null_hit = (imem_instr == IF_NULL_INSTR);
  assign halted   = (state_q == IF_ST_HALT);
`else
  assign null_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  // Next PC/state: a redirect beats everything; otherwise fetch while there is room.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    clr     = 1'b0;
    if (br_taken) begin
      clr     = 1'b1;
      pc_d    = align_word(br_addr);
      state_d = IF_ST_RUN;
    end else if (state_q == IF_ST_RUN && (!fifo_full || pop)) begin
      if (null_hit) begin
        state_d = IF_ST_HALT;
      end else begin
        push = 1'b1;
        pc_d = pc_q + IF_PC_STEP;
      end
    end
  end

  // PC and FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IF_ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .push_i  (push),
    .data_i  (fetched),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios plus randomized
// ready/branch/reset traffic checked by a scoreboard fed from a stream model.
`timescale 1ns/1ps
module tb_if_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] imem_addr, imem_instr, br_addr, out_instr, out_pc;
  logic        br_taken, out_valid, out_ready, halted;

  logic [31:0] w_addr, w_instr, w_out_instr, w_out_pc;
  logic        w_out_valid, w_halted;

  int          n_cmp = 0;
  int          n_err = 0;

  exp_t        exp_q[$];
  logic [31:0] gen_pc;
  bit          gen_stop;

  logic [31:0] seq_words [4] = '{32'hE3A00014, 32'hE3A01A01, 32'hE3A02103, 32'hE0923002};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'hE3A00014;
      32'd4:   return 32'hE3A01A01;
      32'd8:   return 32'hE3A02103;
      32'd12:  return 32'hE0923002;
      default: return 32'h0;
    endcase
  endfunction

  assign imem_instr = mem_word(imem_addr);
  assign w_instr    = w_addr ^ 32'h1234_5678;

  if_fetch_ctrl #(.FIFO_DEPTH(2), .RESET_PC(32'h0)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .halted     (halted)
  );

  if_fetch_ctrl #(.FIFO_DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (w_addr),
    .imem_instr (w_instr),
    .br_taken   (1'b0),
    .br_addr    (32'h0),
    .out_valid  (w_out_valid),
    .out_ready  (1'b1),
    .out_instr  (w_out_instr),
    .out_pc     (w_out_pc),
    .halted     (w_halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stream model: fetch proceeds word by word from the last restart point;
  // with the halt option the stream ends just before the first null word.
  task automatic refill();
    exp_t e;
    while (!gen_stop && exp_q.size() < 16) begin
      e.pc    = gen_pc;
      e.instr = mem_word(gen_pc);
`ifdef IF_HALT_ON_NULL_EN
      if (e.instr == 32'h0) begin
        gen_stop = 1'b1;
        break;
      end
`endif
      exp_q.push_back(e);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] addr);
    exp_q.delete();
    gen_pc   = addr & ~32'h3;
    gen_stop = 1'b0;
    refill();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    refill();
  endtask

  task automatic do_branch(input logic [31:0] addr);
    br_taken = 1'b1;
    br_addr  = addr;
    tick();
    br_taken = 1'b0;
    restart(addr);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    gen_stop = 1'b1;
    tick();
    rst_n = 1'b1;
    restart(32'h0);
  endtask

  // Monitor: every accepted head must be the next word of the modelled stream,
  // and a stalled head must hold still until accepted.
  initial begin : monitor
    logic        hold;
    logic [31:0] hold_pc, hold_instr;
    exp_t        e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", out_valid, 1);
          check("hold_pc", out_pc, hold_pc);
          check("hold_instr", out_instr, hold_instr);
        end
        hold = 1'b0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected: got pc %h with no word expected", out_pc);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc", out_pc, e.pc);
            check("sb_instr", out_instr, e.instr);
          end
        end else if (out_valid && !br_taken) begin
          hold       = 1'b1;
          hold_pc    = out_pc;
          hold_instr = out_instr;
        end
      end
    end
  end

  initial begin : stim
    rst_n     = 1'b0;
    out_ready = 1'b1;
    br_taken  = 1'b0;
    br_addr   = 32'h0;
    gen_pc    = 32'h0;
    gen_stop  = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_instr", out_instr, 0);
    check("rst_pc", out_pc, 0);
    check("rst_halted", halted, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);

    // Stream from reset: first word visible one cycle after release.
    tick();
    rst_n = 1'b1;
    restart(32'h0);
    @(negedge clk);
    check("c0_valid", out_valid, 0);
    check("c0_addr", imem_addr, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("seq_valid", out_valid, 1);
      check("seq_pc", out_pc, 32'(4 * k));
      check("seq_instr", out_instr, seq_words[k]);
      if (k < 3) check("wrap_pc", w_out_pc, 32'hFFFF_FFF8 + 32'(4 * k));
    end

    // Past the last program word: null word at 16.
    @(negedge clk);
`ifdef IF_HALT_ON_NULL_EN
    check("null_halted", halted, 1);
    check("null_valid", out_valid, 0);
    check("null_addr", imem_addr, 32'd16);
    @(negedge clk);
    check("null_addr_hold", imem_addr, 32'd16);
    check("null_halted_hold", halted, 1);
`else
    check("null_valid", out_valid, 1);
    check("null_pc", out_pc, 32'd16);
    check("null_instr", out_instr, 0);
    @(negedge clk);
    check("after_null_pc", out_pc, 32'd20);
`endif
    tick();
    do_branch(32'd4);
    @(negedge clk);
    check("br4_bubble", out_valid, 0);
    check("br4_halted", halted, 0);
    check("br4_addr", imem_addr, 32'd4);
    @(negedge clk);
    check("br4_valid", out_valid, 1);
    check("br4_pc", out_pc, 32'd4);
    check("br4_instr", out_instr, 32'hE3A01A01);

    // Backpressure: queue fills with two entries, PC stalls at 8.
    tick();
    out_ready = 1'b0;
    do_branch(32'd0);
    repeat (2) @(negedge clk);
    check("stall_valid", out_valid, 1);
    repeat (3) @(negedge clk);
    check("stall_pc", out_pc, 32'd0);
    check("stall_instr", out_instr, 32'hE3A00014);
    check("stall_addr", imem_addr, 32'd8);
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("release_pc", out_pc, 32'(4 * k));
    end

    // Branch while full with an unaligned target.
    tick();
    do_branch(32'h0000_000B);
    @(negedge clk);
    check("brB_bubble", out_valid, 0);
    @(negedge clk);
    check("brB_pc", out_pc, 32'd8);
    check("brB_instr", out_instr, 32'hE3A02103);

    // Reset mid-stream takes effect immediately.
    tick();
    out_ready = 1'b0;
    tick();
    check("prerst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    gen_stop = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_addr", imem_addr, 0);
    check("midrst_halted", halted, 0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    restart(32'h0);
    @(negedge clk);
    check("rerst_bubble", out_valid, 0);
    @(negedge clk);
    check("rerst_pc", out_pc, 32'd0);
    check("rerst_wrap_pc", w_out_pc, 32'hFFFF_FFF8);

    // Randomized ready, branches (random low address bits) and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        do_branch(32'($urandom_range(0, 47)));
      end else if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
